move_cmd_encoder: RTL and testbench



---
 rtl/move_cmd_encoder.sv | 185 ++++++++++++++++++
 tb/tb_move_cmd_encoder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/move_cmd_encoder.sv
// Turns debounced direction levels into one-shot move commands on a valid/ready handshake.
// Define MOVE_AUTO_REPEAT_EN to build hold-to-repeat (REPEAT_DELAY, then every REPEAT_PERIOD).
module move_cmd_encoder #(
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000,
   parameter int CNT_W         = 27
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   output logic       cmd_valid,
   output logic [1:0] cmd_dir,
   output logic       cmd_repeat,
   input  logic       cmd_ready
);

   localparam int LIM_MAX =
      (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;

   if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_lim
      $error("repeat limits must be at least 2");
   end
   if (longint'(LIM_MAX - 1) >= (longint'(1) << CNT_W)) begin : g_bad_w
      $error("CNT_W too narrow for repeat limits");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       valid_q, valid_d;
   logic [1:0] dir_q, dir_d;
   logic [1:0] dir_pick;
   logic       any_btn;

   assign any_btn = btn_up | btn_down | btn_left | btn_right;

   always_comb begin
      dir_pick = 2'b00;
      priority case (1'b1)
         btn_up:    dir_pick = 2'b00;
         btn_down:  dir_pick = 2'b01;
         btn_left:  dir_pick = 2'b10;
         btn_right: dir_pick = 2'b11;
         default:   dir_pick = 2'b00;
      endcase
   end

`ifdef MOVE_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] DLY_LIM = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LIM = CNT_W'(REPEAT_PERIOD - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] limit;
   logic             first_q, first_d;
   logic             broken_q, broken_d;
   logic             rep_q, rep_d;
   logic [3:0]       btns;
   logic             latched_hi;
   logic             at_lim;

   assign btns       = {btn_right, btn_left, btn_down, btn_up};
   assign latched_hi = btns[dir_q];
   assign limit      = first_q ? PER_LIM : DLY_LIM;
   assign at_lim     = (cnt_q == limit);

   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      dir_d    = dir_q;
      rep_d    = rep_q;
      cnt_d    = cnt_q;
      first_d  = first_q;
      broken_d = broken_q;
      unique case (state_q)
         IDLE: begin
            if (any_btn) begin
               dir_d   = dir_pick;
               rep_d   = 1'b0;
               valid_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (cmd_ready) begin
               valid_d  = 1'b0;
               cnt_d    = '0;
               broken_d = 1'b0;
               state_d  = HOLD;
            end
         end
         HOLD: begin
            if (!any_btn) begin
               first_d = 1'b0;
               state_d = IDLE;
            end else begin
               // once the latched key lets go, no repeat until full release
               if (!latched_hi) broken_d = 1'b1;
               if (at_lim && latched_hi && !broken_q) begin
                  valid_d = 1'b1;
                  rep_d   = 1'b1;
                  first_d = 1'b1;
                  state_d = ISSUE;
               end else if (!at_lim) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = HOLD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         first_q  <= 1'b0;
         broken_q <= 1'b0;
         rep_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         first_q  <= first_d;
         broken_q <= broken_d;
         rep_q    <= rep_d;
      end
   end

   assign cmd_repeat = rep_q;
`else
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      dir_d   = dir_q;
      unique case (state_q)
         IDLE: begin
            if (any_btn) begin
               dir_d   = dir_pick;
               valid_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (cmd_ready) begin
               valid_d = 1'b0;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (!any_btn) state_d = IDLE;
         end
         default: begin
            valid_d = 1'b0;
            state_d = HOLD;
         end
      endcase
   end

   assign cmd_repeat = 1'b0;
`endif

   // reset parks in HOLD so a key held through reset is ignored
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HOLD;
         valid_q <= 1'b0;
         dir_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         dir_q   <= dir_d;
      end
   end

   assign cmd_valid = valid_q;
   assign cmd_dir   = dir_q;

endmodule

// File: tb/tb_move_cmd_encoder.sv
// Directed bench for move_cmd_encoder with REPEAT_DELAY=8, REPEAT_PERIOD=4.
module tb_move_cmd_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_up, btn_down, btn_left, btn_right;
   logic       cmd_valid;
   logic [1:0] cmd_dir;
   logic       cmd_repeat;
   logic       cmd_ready;

   int passed = 0;
   int total  = 0;

   move_cmd_encoder #(
      .REPEAT_DELAY (8),
      .REPEAT_PERIOD(4),
      .CNT_W        (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .cmd_valid (cmd_valid),
      .cmd_dir   (cmd_dir),
      .cmd_repeat(cmd_repeat),
      .cmd_ready (cmd_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic exp_v;
      rst_n = 1'b0;
      btn_up = 1'b0; btn_down = 1'b0;
      btn_left = 1'b1; btn_right = 1'b0;
      cmd_ready = 1'b1;

      // reset with left held
      cyc(2);
      chk("rst_valid", {3'b0, cmd_valid}, 4'h0);
      chk("rst_dir", {2'b0, cmd_dir}, 4'h0);
      chk("rst_rep", {3'b0, cmd_repeat}, 4'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("held_thru_rst", {3'b0, cmd_valid}, 4'h0);
      end
      btn_left = 1'b0;
      cyc(1);
      btn_left = 1'b1;
      cyc(1);
      chk("left_valid", {3'b0, cmd_valid}, 4'h1);
      chk("left_dir", {2'b0, cmd_dir}, 4'h2);
      chk("left_rep", {3'b0, cmd_repeat}, 4'h0);
      cyc(1);
      chk("left_one_cyc", {3'b0, cmd_valid}, 4'h0);
      btn_left = 1'b0;
      cyc(1);

      // stalled handshake on right
      btn_right = 1'b1;
      cmd_ready = 1'b0;
      cyc(1);
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", {3'b0, cmd_valid}, 4'h1);
         chk("stall_dir", {2'b0, cmd_dir}, 4'h3);
         if (i == 4) cmd_ready = 1'b1;
         cyc(1);
      end
      chk("stall_drop", {3'b0, cmd_valid}, 4'h0);
      btn_right = 1'b0;
      cyc(1);

      // up and right together
      btn_up = 1'b1;
      btn_right = 1'b1;
      cyc(1);
      chk("prio_valid", {3'b0, cmd_valid}, 4'h1);
      chk("prio_dir", {2'b0, cmd_dir}, 4'h0);
      cyc(1);
      chk("prio_single", {3'b0, cmd_valid}, 4'h0);
      btn_up = 1'b0;
      btn_right = 1'b0;
      cyc(1);

      // hold up, add left, drop up: nothing until full release
      btn_up = 1'b1;
      cyc(1);
      chk("swap_first", {3'b0, cmd_valid}, 4'h1);
      cyc(1);
      btn_left = 1'b1;
      cyc(1);
      btn_up = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         chk("swap_quiet", {3'b0, cmd_valid}, 4'h0);
      end
      btn_left = 1'b0;
      cyc(1);
      chk("swap_idle", {3'b0, cmd_valid}, 4'h0);

      // down held 30 cycles
      btn_down = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         cyc(1);
`ifdef MOVE_AUTO_REPEAT_EN
         exp_v = (c == 1) || (c >= 10 && (c - 10) % 5 == 0);
`else
         exp_v = (c == 1);
`endif
         chk($sformatf("hold_valid_c%0d", c), {3'b0, cmd_valid},
             {3'b0, exp_v});
         if (exp_v) begin
            chk("hold_dir", {2'b0, cmd_dir}, 4'h1);
            chk("hold_rep", {3'b0, cmd_repeat}, {3'b0, c > 1});
         end
      end
      btn_down = 1'b0;
      cyc(3);
      chk("hold_end", {3'b0, cmd_valid}, 4'h0);

      // release exactly on the repeat-limit edge
      btn_down = 1'b1;
      cyc(1);
      chk("race_first", {3'b0, cmd_valid}, 4'h1);
      for (int c = 2; c <= 9; c++) begin
         cyc(1);
         chk("race_quiet", {3'b0, cmd_valid}, 4'h0);
      end
      btn_down = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("race_norep", {3'b0, cmd_valid}, 4'h0);
      end

      // async reset mid-ISSUE
      cmd_ready = 1'b0;
      btn_right = 1'b1;
      cyc(1);
      chk("arst_pre", {3'b0, cmd_valid}, 4'h1);
      #2 rst_n = 1'b0;
      #1 chk("arst_drop", {3'b0, cmd_valid}, 4'h0);
      chk("arst_dir", {2'b0, cmd_dir}, 4'h0);
      btn_right = 1'b0;
      cmd_ready = 1'b1;
      cyc(1);
      rst_n = 1'b1;
      cyc(2);
      chk("arst_quiet", {3'b0, cmd_valid}, 4'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
